// File: rtl/delay_tap_pkg.sv
// Shared types and helpers for the configurable-delay tap line.
package delay_tap_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    APPLY = 2'd2
  } state_t;

  localparam int STAT_W = 16;

  function automatic int unsigned delay_clamp(input int unsigned req, input int unsigned depth);
    return (req > depth) ? depth : req;
  endfunction

endpackage

// File: rtl/delay_tap_stage.sv
// One delay-line stage: data register plus valid bit.
// The valid clear wins over advance so a reconfiguration empties the line in one cycle.
module delay_tap_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             v,
  output logic [WIDTH-1:0] q,
  output logic             qv
);

  logic [WIDTH-1:0] data_reg;
  logic             valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      if (adv) data_reg <= d;
      if (clr) valid_reg <= 1'b0;
      else if (adv) valid_reg <= v;
    end
  end

  assign q  = data_reg;
  assign qv = valid_reg;

endmodule

// File: rtl/delay_tap_ctrl.sv
// Configurable-delay tap line with valid/ready handshakes and drain-before-apply reconfiguration.
// Define DELAY_TAP_STATS_EN to add the beat_cnt / drain_cyc statistics outputs.
module delay_tap_ctrl
  import delay_tap_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 3,
  parameter int RST_DELAY = 0,
  localparam int DW       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  input  logic [DW-1:0]     cfg_delay,
  input  logic              cfg_load,
  output logic [DW-1:0]     cur_delay,
  output logic              busy
`ifdef DELAY_TAP_STATS_EN
  ,
  output logic [STAT_W-1:0] beat_cnt,
  output logic [STAT_W-1:0] drain_cyc
`endif
);

  state_t            state_reg, state_next;
  logic [DW-1:0]     cur_reg, cur_next;
  logic [DW-1:0]     pend_reg, pend_next;
  logic [DW-1:0]     req_clamped;
  logic [WIDTH-1:0]  stage_d [DEPTH];
  logic              stage_v [DEPTH];
  logic [WIDTH-1:0]  tap_d;
  logic              tap_v;
  logic              drained;
  logic              run;
  logic              advance;
  logic              accept;
  logic              apply_clr;

  assign req_clamped = DW'(delay_clamp(32'(cfg_delay), DEPTH));
  assign run         = (state_reg == RUN);
  assign apply_clr   = (state_reg == APPLY);

  // Tap select and "old taps empty" detection over stages 1..cur_delay.
  always_comb begin
    tap_d   = '0;
    tap_v   = 1'b0;
    drained = 1'b1;
    for (int k = 1; k <= DEPTH; k++) begin
      if (cur_reg == DW'(k)) begin
        tap_d = stage_d[k-1];
        tap_v = stage_v[k-1];
      end
      if ((DW'(k) <= cur_reg) && stage_v[k-1]) drained = 1'b0;
    end
  end

  always_comb begin
    if (cur_reg == '0) begin
      out_data  = in_data;
      out_valid = in_valid & run;
      in_ready  = out_ready & run;
    end else begin
      out_data  = tap_d;
      out_valid = tap_v & ~apply_clr;
      in_ready  = ~(out_valid & ~out_ready) & run;
    end
    advance = ~(out_valid & ~out_ready);
    accept  = in_valid & in_ready;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [WIDTH-1:0] d_in;
    logic             v_in;
    if (gi == 0) begin : g_first
      assign d_in = in_data;
      assign v_in = accept;
    end else begin : g_rest
      assign d_in = stage_d[gi-1];
      assign v_in = stage_v[gi-1];
    end
    delay_tap_stage #(.WIDTH(WIDTH)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (advance),
      .clr   (apply_clr),
      .d     (d_in),
      .v     (v_in),
      .q     (stage_d[gi]),
      .qv    (stage_v[gi])
    );
  end

  always_comb begin
    state_next = state_reg;
    cur_next   = cur_reg;
    pend_next  = pend_reg;
    unique case (state_reg)
      RUN: begin
        if (cfg_load && (req_clamped != cur_reg)) begin
          pend_next  = req_clamped;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (drained) state_next = APPLY;
      end
      APPLY: begin
        cur_next   = pend_reg;
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RUN;
      cur_reg   <= DW'(RST_DELAY);
      pend_reg  <= DW'(RST_DELAY);
    end else begin
      state_reg <= state_next;
      cur_reg   <= cur_next;
      pend_reg  <= pend_next;
    end
  end

  assign cur_delay = cur_reg;
  assign busy      = ~run;

`ifdef DELAY_TAP_STATS_EN
  logic [STAT_W-1:0] beat_reg;
  logic [STAT_W-1:0] drain_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_reg  <= '0;
      drain_reg <= '0;
    end else begin
      if (out_valid && out_ready && (beat_reg != '1)) beat_reg <= beat_reg + 1'b1;
      if (!run && (drain_reg != '1)) drain_reg <= drain_reg + 1'b1;
    end
  end

  assign beat_cnt  = beat_reg;
  assign drain_cyc = drain_reg;
`endif

endmodule
